// File: rtl/checksum_verify.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : checksum_verify
// Purpose  : Byte-serial receiver/checker for the cluster checksum format.
//            Each cluster is CLUSTER_BYTES data bytes followed by one checksum
//            byte (two's complement of the 8-bit data sum). Data bytes are
//            forwarded through a one-entry output register; checksum bytes
//            are consumed and turned into per-cluster and per-frame results.
// Optional : `define CHK_ERR_COUNT_EN adds the err_count output (failing
//            clusters in the current frame).
// Ports    :
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous frame abort
//   in_valid     in_byte valid
//   in_ready     block accepts in_byte this cycle
//   in_byte[7:0] stream byte (data or checksum)
//   out_valid    out_byte holds a forwarded data byte
//   out_ready    downstream accepts out_byte
//   out_byte     forwarded data byte
//   clu_valid    one-cycle pulse, cluster result available
//   clu_ok       cluster checksum matched (valid with clu_valid)
//   frame_valid  one-cycle pulse, frame complete
//   frame_ok     every cluster of the frame matched (valid with frame_valid)
//   err_count    failing clusters in frame (CHK_ERR_COUNT_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module checksum_verify #(
   parameter int CLUSTER_BYTES = 4,
   parameter int NUM_CLUSTERS  = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_byte,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_byte,
   output logic       clu_valid,
   output logic       clu_ok,
   output logic       frame_valid,
   output logic       frame_ok
`ifdef CHK_ERR_COUNT_EN
   ,
   output logic [7:0] err_count
`endif
);

   localparam logic [3:0] c_last_byte = 4'(CLUSTER_BYTES - 1);
   localparam logic [7:0] c_last_clu  = 8'(NUM_CLUSTERS - 1);

   typedef enum logic [0:0] {
      ST_DATA = 1'b0,
      ST_CHK  = 1'b1
   } state_t;

   state_t     r_state;
   logic [3:0] r_byte_cnt;
   logic [7:0] r_clu_cnt;
   logic [7:0] r_sum;
   logic       r_frame_err;
   logic       r_out_valid;
   logic [7:0] r_out_byte;
   logic       r_clu_valid;
   logic       r_clu_ok;
   logic       r_frame_valid;
   logic       r_frame_ok;

   logic       w_in_ready;
   logic       w_accept;
   logic       w_load;
   logic       w_chk;
   logic [7:0] w_sum_next;
   logic       w_ok;

   // In DATA a byte can only be taken if the output register is free or is
   // being emptied this cycle; checksum bytes are never forwarded, so CHK
   // can always accept.
   assign w_in_ready = (r_state == ST_CHK) | ~r_out_valid | out_ready;
   assign w_accept   = in_valid & w_in_ready;
   // flush wins over a simultaneous accept: the byte is acknowledged but
   // has no effect.
   assign w_load     = w_accept & ~flush & (r_state == ST_DATA);
   assign w_chk      = w_accept & ~flush & (r_state == ST_CHK);
   assign w_sum_next = r_sum + in_byte;
   assign w_ok       = (w_sum_next == 8'h00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_DATA;
         r_byte_cnt    <= 4'd0;
         r_clu_cnt     <= 8'd0;
         r_sum         <= 8'd0;
         r_frame_err   <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_byte    <= 8'd0;
         r_clu_valid   <= 1'b0;
         r_clu_ok      <= 1'b0;
         r_frame_valid <= 1'b0;
         r_frame_ok    <= 1'b0;
      end else begin
         // result outputs are single-cycle pulses and read 0 otherwise
         r_clu_valid   <= 1'b0;
         r_clu_ok      <= 1'b0;
         r_frame_valid <= 1'b0;
         r_frame_ok    <= 1'b0;

         // output register: a held byte survives flush until consumed
         if (w_load) begin
            r_out_byte  <= in_byte;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (flush) begin
            r_state     <= ST_DATA;
            r_byte_cnt  <= 4'd0;
            r_clu_cnt   <= 8'd0;
            r_sum       <= 8'd0;
            r_frame_err <= 1'b0;
         end else if (w_load) begin
            r_sum <= w_sum_next;
            if (r_byte_cnt == c_last_byte) begin
               r_byte_cnt <= 4'd0;
               r_state    <= ST_CHK;
            end else begin
               r_byte_cnt <= r_byte_cnt + 4'd1;
            end
         end else if (w_chk) begin
            r_clu_valid <= 1'b1;
            r_clu_ok    <= w_ok;
            r_sum       <= 8'd0;
            r_state     <= ST_DATA;
            if (r_clu_cnt == c_last_clu) begin
               r_clu_cnt     <= 8'd0;
               r_frame_valid <= 1'b1;
               r_frame_ok    <= ~(r_frame_err | ~w_ok);
               r_frame_err   <= 1'b0;
            end else begin
               r_clu_cnt   <= r_clu_cnt + 8'd1;
               r_frame_err <= r_frame_err | ~w_ok;
            end
         end
      end
   end

`ifdef CHK_ERR_COUNT_EN
   logic [7:0] r_err_count;
   logic [7:0] w_err_base;

   // The count is read in the frame_valid cycle, so it is cleared on the
   // following edge; a checksum accept cannot coincide with that edge
   // (at least two data bytes separate checksums), but stacking the clear
   // under the increment keeps the ordering explicit anyway.
   assign w_err_base = r_frame_valid ? 8'd0 : r_err_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count <= 8'd0;
      end else if (flush) begin
         r_err_count <= 8'd0;
      end else if (w_chk && !w_ok) begin
         r_err_count <= w_err_base + 8'd1;
      end else begin
         r_err_count <= w_err_base;
      end
   end

   assign err_count = r_err_count;
`endif

   assign in_ready    = w_in_ready;
   assign out_valid   = r_out_valid;
   assign out_byte    = r_out_byte;
   assign clu_valid   = r_clu_valid;
   assign clu_ok      = r_clu_ok;
   assign frame_valid = r_frame_valid;
   assign frame_ok    = r_frame_ok;

endmodule
`default_nettype wire

// File: tb/tb_checksum_verify.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_checksum_verify
// Purpose  : Self-checking bench for checksum_verify. Directed steps drive the
//            byte stream; expected forwarded bytes and cluster/frame results
//            are queued by the driver tasks and compared by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_checksum_verify;

   localparam int CB = 4;
   localparam int NC = 6;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       flush     = 1'b0;
   logic       in_valid  = 1'b0;
   logic [7:0] in_byte   = 8'd0;
   logic       out_ready = 1'b1;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_byte;
   logic       clu_valid;
   logic       clu_ok;
   logic       frame_valid;
   logic       frame_ok;
`ifdef CHK_ERR_COUNT_EN
   logic [7:0] err_count;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   checksum_verify #(.CLUSTER_BYTES(CB), .NUM_CLUSTERS(NC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_byte     (in_byte),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_byte    (out_byte),
      .clu_valid   (clu_valid),
      .clu_ok      (clu_ok),
      .frame_valid (frame_valid),
      .frame_ok    (frame_ok)
`ifdef CHK_ERR_COUNT_EN
      ,
      .err_count   (err_count)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       ok;
      logic       last;
      logic       fok;
      logic [7:0] errs;
      int         cyc;
   } clu_exp_t;

   logic [7:0] exp_out[$];
   clu_exp_t   exp_clu[$];
   clu_exp_t   mon_e;

   // reference model state
   logic [7:0] m_sum   = 8'd0;
   int         m_clu   = 0;
   logic       m_ferr  = 1'b0;
   int         m_errs  = 0;
   int         m_first = 0;
   bit         m_started = 1'b0;
   bit         tp_check  = 1'b0;
   int         clu_pulses = 0;
   int         bp_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // out_ready stalls for bp_cnt cycles when requested
   always @(negedge clk) begin
      if (bp_cnt > 0) begin
         out_ready = 1'b0;
         bp_cnt    = bp_cnt - 1;
      end else begin
         out_ready = 1'b1;
      end
   end

   // monitor: sampled mid-cycle, after the bench has driven its inputs
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_out.size() == 0) chk("out_unexpected", 32'(out_valid), 32'd0);
            else                     chk("out_byte", 32'(out_byte), 32'(exp_out.pop_front()));
         end
         if (clu_valid === 1'b1) begin
            clu_pulses++;
            if (exp_clu.size() == 0) begin
               chk("clu_unexpected", 32'(clu_valid), 32'd0);
            end else begin
               mon_e = exp_clu.pop_front();
               chk("clu_cycle", 32'(cyc), 32'(mon_e.cyc));
               chk("clu_ok", 32'(clu_ok), 32'(mon_e.ok));
               chk("frame_valid", 32'(frame_valid), 32'(mon_e.last));
               if (mon_e.last) begin
                  chk("frame_ok", 32'(frame_ok), 32'(mon_e.fok));
`ifdef CHK_ERR_COUNT_EN
                  chk("err_count", 32'(err_count), 32'(mon_e.errs));
`endif
               end
            end
         end else begin
            chk("idle_pulses", 32'({clu_ok, frame_valid, frame_ok}), 32'd0);
         end
      end
   end

   task automatic send(input logic [7:0] b, output int acc);
      int guard;
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = b;
      #1;
      guard = 0;
      while (in_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (guard >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      acc = cyc + 1;
      @(posedge clk);
   endtask

   task automatic send_data(input logic [7:0] b);
      int a;
      exp_out.push_back(b);
      m_sum = m_sum + b;
      send(b, a);
      if (!m_started) begin
         m_first   = a;
         m_started = 1'b1;
      end
   endtask

   task automatic send_chk(input logic [7:0] c);
      int         a;
      logic [7:0] s;
      clu_exp_t   e;
      s      = m_sum + c;
      e.ok   = (s == 8'h00);
      e.last = (m_clu == NC - 1);
      if (!e.ok) m_errs++;
      m_ferr = m_ferr | ~e.ok;
      e.fok  = ~m_ferr;
      e.errs = 8'(m_errs);
      send(c, a);
      e.cyc = a;
      exp_clu.push_back(e);
      if (e.last && tp_check) chk("frame_latency", 32'(a - m_first), 32'd29);
      m_sum = 8'd0;
      if (e.last) begin
         m_clu = 0; m_ferr = 1'b0; m_errs = 0; m_started = 1'b0;
      end else begin
         m_clu++;
      end
   endtask

   task automatic model_clear();
      m_sum = 8'd0; m_clu = 0; m_ferr = 1'b0; m_errs = 0; m_started = 1'b0;
   endtask

   task automatic send_cluster(input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3,
                               input logic [7:0] ck);
      send_data(d0); send_data(d1); send_data(d2); send_data(d3); send_chk(ck);
   endtask

   task automatic good_frame();
      for (int i = 0; i < NC; i++) send_cluster(8'h41, 8'h42, 8'h43, 8'h44, 8'hF6);
   endtask

   task automatic drain();
      int g;
      @(negedge clk);
      in_valid = 1'b0;
      g = 0;
      while ((exp_out.size() != 0 || exp_clu.size() != 0) && g < 50) begin
         @(negedge clk);
         g++;
      end
      repeat (3) @(negedge clk);
      chk("drain_out", 32'(exp_out.size()), 32'd0);
      chk("drain_clu", 32'(exp_clu.size()), 32'd0);
   endtask

   initial begin
      int p0;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_outs", 32'({out_valid, clu_valid, clu_ok, frame_valid, frame_ok}), 32'd0);
      chk("rst_out_byte", 32'(out_byte), 32'd0);
`ifdef CHK_ERR_COUNT_EN
      chk("rst_err_count", 32'(err_count), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // good frame at full rate
      p0 = clu_pulses;
      tp_check = 1'b1;
      good_frame();
      tp_check = 1'b0;
      drain();
      chk("good_pulses", 32'(clu_pulses - p0), 32'd6);

      // bad third cluster, then a good frame
      for (int i = 0; i < NC; i++)
         send_cluster(8'h41, 8'h42, 8'h43, 8'h44, (i == 2) ? 8'hF5 : 8'hF6);
      good_frame();
      drain();

      // wrap-around / zero sums
      send_cluster(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      send_cluster(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h04);
      send_cluster(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
      for (int i = 0; i < 3; i++) send_cluster(8'h41, 8'h42, 8'h43, 8'h44, 8'hF6);
      drain();

      // backpressure after the first data byte
      send_data(8'h41);
      bp_cnt = 5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #2;
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_hold", 32'({out_valid, out_byte}), 32'h141);
      end
      send_data(8'h42); send_data(8'h43); send_data(8'h44); send_chk(8'hF6);
      for (int i = 1; i < NC; i++) send_cluster(8'h41, 8'h42, 8'h43, 8'h44, 8'hF6);
      drain();

      // flush on the second byte of cluster 2, together with an accept
      p0 = clu_pulses;
      send_cluster(8'h41, 8'h42, 8'h43, 8'h44, 8'hF6);
      send_data(8'h41);
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = 8'h42;
      flush    = 1'b1;
      #1;
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      model_clear();
      repeat (8) @(negedge clk);
      chk("flush_no_pulse", 32'(clu_pulses - p0), 32'd1);
      p0 = clu_pulses;
      good_frame();
      drain();
      chk("post_flush_pulses", 32'(clu_pulses - p0), 32'd6);

      // asynchronous reset between edges, mid-cluster
      send_data(8'h41);
      send_data(8'h42);
      #2;
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_outs", 32'({out_valid, clu_valid, frame_valid}), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      exp_out.delete();
      exp_clu.delete();
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      p0 = clu_pulses;
      good_frame();
      drain();
      chk("post_rst_pulses", 32'(clu_pulses - p0), 32'd6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/checksum_verify.md
Name: checksum_verify

Overview:
- Byte-serial receiver/checker for the cluster checksum format: each cluster is CLUSTER_BYTES ASCII data bytes followed by one checksum byte.
- The checksum byte is the two's complement of the 8-bit sum of the data bytes.
- Accepts a valid/ready byte stream, strips checksum bytes and forwards data bytes through a one-entry output register.
- Reports pass/fail per cluster and per frame of NUM_CLUSTERS clusters. Sits on the receive side, after the byte deserializer.

Parameters:
- CLUSTER_BYTES, 4, data bytes per cluster (2..15).
- NUM_CLUSTERS, 6, clusters per frame (1..255); 6x4 = 24 data bytes = 192-bit payload.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous frame abort; clears counters, accumulator and frame status.
- in_valid  input  1  in_byte valid.
- in_ready  output  1  block accepts in_byte this cycle.
- in_byte  input  8  stream byte, data or checksum.
- out_valid  output  1  out_byte holds a forwarded data byte.
- out_ready  input  1  downstream accepts out_byte.
- out_byte  output  8  forwarded data byte.
- clu_valid  output  1  one-cycle pulse: cluster result available.
- clu_ok  output  1  cluster checksum matched; meaningful while clu_valid.
- frame_valid  output  1  one-cycle pulse: frame complete.
- frame_ok  output  1  every cluster in frame matched; meaningful while frame_valid.

Behaviour:
- Reset: all outputs 0 except in_ready = 1. State DATA; byte_cnt, clu_cnt, sum = 0; frame_err = 0.
- Accept: a byte is accepted when in_valid & in_ready are high at the clk edge.
- State DATA:
  - in_ready = !out_valid | out_ready.
  - On accept: out_byte <= in_byte; out_valid <= 1 (next cycle); sum <= sum + in_byte, mod 256.
  - byte_cnt increments. After the accept with byte_cnt == CLUSTER_BYTES-1, go to CHK and reset byte_cnt to 0.
- State CHK:
  - in_ready = 1; the checksum byte is never forwarded.
  - On accept: ok = ((sum + in_byte) mod 256 == 0).
  - Next cycle: clu_valid = 1 for exactly one cycle, clu_ok = ok. sum <= 0; frame_err <= frame_err | !ok; state <= DATA.
  - If clu_cnt == NUM_CLUSTERS-1: clu_cnt <= 0; frame_valid pulses in the same cycle as that clu_valid; frame_ok = !(frame_err | !ok); frame_err <= 0.
  - Otherwise clu_cnt increments.
- Output register: out_valid clears when out_ready is high and no new byte is loaded that cycle. out_byte is stable while out_valid & !out_ready.
- Latency: data byte accept to out_valid = 1 cycle. Checksum accept to clu_valid/frame_valid = 1 cycle.
- Pulse width: clu_valid/clu_ok and frame_valid/frame_ok are registered and hold 0 outside their pulse cycle.
- Back-to-back: the block sustains 1 byte/cycle when out_ready = 1, including DATA->CHK->DATA transitions.
- Flush:
  - flush has priority over a simultaneous accept. The byte is acknowledged (in_ready unaffected) and dropped.
  - State <= DATA; counters, sum and frame_err cleared. No clu_valid/frame_valid is generated for the aborted frame.
  - A pending out_valid byte is retained until consumed.
- Wrap-around: the sum is modulo 256 with no carry retained. A data sum of 0x00 requires checksum 0x00.
- Mid-operation reset: asserting rst_n low at any time returns all state to reset values immediately, without waiting for clk.

Optional Feature:
- Macro: CHK_ERR_COUNT_EN.
- Defined: adds output err_count, 8 bits, wide enough for NUM_CLUSTERS up to 255.
  - Counts failing clusters in the current frame; increments in the clu_valid cycle when clu_ok = 0.
  - Value is valid in the frame_valid cycle. Cleared to 0 the cycle after frame_valid, on flush, and on reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Good frame: 6 clusters of 41 42 43 44 F6 (sum 0x10A -> 0x0A, check 0xF6), in_valid = 1, out_ready = 1 -> 24 out bytes 41,42,43,44 repeated. 6 clu_valid pulses with clu_ok = 1. frame_valid with frame_ok = 1 on the 30th cycle after the first accept.
- Bad cluster: same frame, cluster 3 checksum F5 -> clu_ok = 0 only on the 3rd pulse; frame_ok = 0. With CHK_ERR_COUNT_EN, err_count = 1 at frame_valid. Next good frame -> frame_ok = 1.
- Wrap/zero: cluster 00 00 00 00 00 -> clu_ok = 1. Cluster FF FF FF FF 04 (sum 0x3FC -> FC) -> clu_ok = 1. Cluster FF FF FF FF 00 -> clu_ok = 0.
- Backpressure: out_ready low for 5 cycles after the first data byte -> in_ready low while out_valid & !out_ready; out_byte holds 0x41; no byte lost or duplicated; results identical to the good-frame case.
- Flush: flush during the 2nd byte of cluster 2 together with an accept -> no clu/frame pulses. A following full good frame -> exactly 6 clu_valid and frame_ok = 1.
- Async reset mid-cluster: rst_n low between clk edges -> out_valid, clu_valid, frame_valid = 0 immediately. After release, a good frame passes.
